// File: rtl/exc_seq_if.sv
// Signal bundle between the exception sequencer, the INTC and the CPU bus/register file.
// Suffixes are from the sequencer's point of view.
interface exc_seq_if;
  logic        int_req_i;
  logic [3:0]  int_lvl_i;
  logic [7:0]  int_vec_i;
  logic [3:0]  int_mask_o;
  logic        int_ack_o;
  logic        int_acp_o;
  logic        vect_req_o;
  logic        vect_wait_i;
  logic        inst_bound_i;
  logic [31:0] sr_in_i;
  logic [31:0] pc_in_i;
  logic [31:0] sp_in_i;
  logic [31:0] vbr_i;
  logic [31:0] bus_a_o;
  logic [31:0] bus_do_o;
  logic [31:0] bus_di_i;
  logic        bus_we_o;
  logic        bus_req_o;
  logic        bus_busy_i;
  logic [31:0] new_pc_o;
  logic [31:0] new_sr_o;
  logic [31:0] new_sp_o;
  logic        load_o;

  modport slave (
    input  int_req_i, int_lvl_i, int_vec_i, vect_wait_i, inst_bound_i,
           sr_in_i, pc_in_i, sp_in_i, vbr_i, bus_di_i, bus_busy_i,
    output int_mask_o, int_ack_o, int_acp_o, vect_req_o,
           bus_a_o, bus_do_o, bus_we_o, bus_req_o,
           new_pc_o, new_sr_o, new_sp_o, load_o
  );

  modport master (
    output int_req_i, int_lvl_i, int_vec_i, vect_wait_i, inst_bound_i,
           sr_in_i, pc_in_i, sp_in_i, vbr_i, bus_di_i, bus_busy_i,
    input  int_mask_o, int_ack_o, int_acp_o, vect_req_o,
           bus_a_o, bus_do_o, bus_we_o, bus_req_o,
           new_pc_o, new_sr_o, new_sp_o, load_o
  );
endinterface

// File: rtl/exc_seq.sv
// SH-style interrupt acceptance sequencer: acknowledges the INTC, pushes SR/PC,
// fetches the handler vector and hands NEW_PC/SR/SP to the CPU in one LOAD pulse.
module exc_seq (
  input  logic      clk,
  input  logic      rst,
  input  logic      ce_i,
  exc_seq_if.slave  cpu
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_PUSH_SR, S_PUSH_PC, S_VECT, S_VRD, S_LOAD
  } state_e;

  localparam logic [7:0] NMI_VEC = 8'd11;

  state_e      state_q, state_d;
  logic        vect_2nd_q, vect_2nd_d;
  logic [3:0]  lvl_q;
  logic [7:0]  vec_q;
  logic [31:0] sr_q, pc_q, sp_q, vbr_q;
  logic        int_ack_q, int_acp_q, vect_req_q, load_q;
  logic [31:0] new_pc_q, new_sr_q, new_sp_q;

  logic        accept;
  logic        bus_req;
  logic        xfer_done;
  logic [31:0] bus_a, bus_do;
  logic        bus_we;

  // NMI bypasses the level comparison entirely.
  assign accept = cpu.inst_bound_i && cpu.int_req_i &&
                  ((cpu.int_lvl_i > cpu.sr_in_i[7:4]) || (cpu.int_vec_i == NMI_VEC));

  // Bus decode is a pure function of the state register so A/DO/WE hold across busy cycles.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    bus_req = 1'b0;
    bus_we  = 1'b0;
    bus_a   = 32'h0;
    bus_do  = 32'h0;
    case (state_q)
      S_PUSH_SR: begin
        bus_req = 1'b1;
        bus_we  = 1'b1;
        bus_a   = sp_q - 32'd4;
        bus_do  = sr_q;
      end
      S_PUSH_PC: begin
        bus_req = 1'b1;
        bus_we  = 1'b1;
        bus_a   = sp_q - 32'd8;
        bus_do  = pc_q;
      end
      S_VRD: begin
        bus_req = 1'b1;
        bus_a   = vbr_q + {22'b0, vec_q, 2'b00};
      end
      default: ;
    endcase
  end

  assign xfer_done = bus_req && !cpu.bus_busy_i;

  always_comb begin
    state_d    = state_q;
    vect_2nd_d = 1'b0;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_ACK;
      S_ACK:     state_d = S_PUSH_SR;
      S_PUSH_SR: if (xfer_done) state_d = S_PUSH_PC;
      S_PUSH_PC: if (xfer_done) state_d = S_VECT;
      S_VECT: begin
        // The first VECT cycle is unconditional; VECT_WAIT only matters from the second.
        vect_2nd_d = 1'b1;
        if (vect_2nd_q && !cpu.vect_wait_i) state_d = S_VRD;
      end
      S_VRD:     if (xfer_done) state_d = S_LOAD;
      S_LOAD:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      vect_2nd_q <= 1'b0;
      lvl_q      <= 4'h0;
      vec_q      <= 8'h0;
      sr_q       <= 32'h0;
      pc_q       <= 32'h0;
      sp_q       <= 32'h0;
      vbr_q      <= 32'h0;
      int_ack_q  <= 1'b0;
      int_acp_q  <= 1'b0;
      vect_req_q <= 1'b0;
      load_q     <= 1'b0;
      new_pc_q   <= 32'h0;
      new_sr_q   <= 32'h0;
      new_sp_q   <= 32'h0;
    end else if (ce_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      vect_2nd_q <= vect_2nd_d;
      if (state_q == S_IDLE && accept) begin
        lvl_q <= cpu.int_lvl_i;
        vec_q <= cpu.int_vec_i;
        sr_q  <= cpu.sr_in_i;
        pc_q  <= cpu.pc_in_i;
        sp_q  <= cpu.sp_in_i;
        vbr_q <= cpu.vbr_i;
      end
      if (state_q == S_VRD && xfer_done) new_pc_q <= cpu.bus_di_i;
      if (state_d == S_LOAD) begin
        new_sp_q <= sp_q - 32'd8;
        new_sr_q <= {sr_q[31:8], (vec_q == NMI_VEC) ? 4'hF : lvl_q, sr_q[3:0]};
      end
      // Registered outputs are decoded from the next state so they line up with it.
      int_ack_q  <= (state_d == S_ACK);
      int_acp_q  <= (state_d != S_IDLE);
      vect_req_q <= (state_d == S_VECT);
      load_q     <= (state_d == S_LOAD);
    end
  end

  // Mask is forced to F mid-sequence so the INTC presents nothing new.
  assign cpu.int_mask_o = (state_q == S_IDLE) ? cpu.sr_in_i[7:4] : 4'hF;
  assign cpu.int_ack_o  = int_ack_q;
  assign cpu.int_acp_o  = int_acp_q;
  assign cpu.vect_req_o = vect_req_q;
  assign cpu.load_o     = load_q;
  assign cpu.new_pc_o   = new_pc_q;
  assign cpu.new_sr_o   = new_sr_q;
  assign cpu.new_sp_o   = new_sp_q;
  assign cpu.bus_a_o    = bus_a;
  assign cpu.bus_do_o   = bus_do;
  assign cpu.bus_we_o   = bus_we;
  assign cpu.bus_req_o  = bus_req;

endmodule

// File: tb/tb_exc_seq.sv
// Self-checking bench for exc_seq: directed cases plus randomized interrupts
// compared against a transaction-level model of the exception sequence.
module tb_exc_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;

  exc_seq_if ifc ();

  exc_seq dut (
    .clk  (clk),
    .rst  (rst),
    .ce_i (ce),
    .cpu  (ifc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Bus / vector responder configuration and transfer log.
  int          busy_cfg = 0;
  int          vw_cfg   = 0;
  logic [31:0] rd_cfg   = 32'h0;
  logic [31:0] log_a[$];
  logic [31:0] log_d[$];
  logic        log_we[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // Responder runs just after each falling edge: decides BUS_BUSY/VECT_WAIT for the
  // coming edge and logs transfers that will complete on it.
  int          wcnt = 0;
  int          vcyc = 0;
  logic        prev_busy = 1'b0;
  logic [31:0] prev_a = 32'h0;
  logic [31:0] prev_d = 32'h0;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      wcnt = 0;
      vcyc = 0;
      prev_busy = 1'b0;
      ifc.bus_busy_i  = 1'b0;
      ifc.vect_wait_i = 1'b0;
    end else if (ce) begin
      if (prev_busy && ifc.bus_req_o) begin
        check("a_stable_busy", ifc.bus_a_o, prev_a);
        check("do_stable_busy", ifc.bus_do_o, prev_d);
      end
      if (!ifc.bus_req_o) begin
        wcnt = 0;
        ifc.bus_busy_i = 1'b0;
      end else if (wcnt < busy_cfg) begin
        wcnt++;
        ifc.bus_busy_i = 1'b1;
      end else begin
        wcnt = 0;
        ifc.bus_busy_i = 1'b0;
        log_a.push_back(ifc.bus_a_o);
        log_d.push_back(ifc.bus_do_o);
        log_we.push_back(ifc.bus_we_o);
      end
      prev_busy = ifc.bus_busy_i;
      prev_a    = ifc.bus_a_o;
      prev_d    = ifc.bus_do_o;
      ifc.bus_di_i = ifc.bus_busy_i ? 32'hDEAD_BEEF : rd_cfg;
      if (!ifc.vect_req_o) begin
        vcyc = 0;
        ifc.vect_wait_i = 1'b0;
      end else begin
        vcyc++;
        ifc.vect_wait_i = (vcyc <= vw_cfg);
      end
    end
  end

  // One full interrupt; caller must be positioned at a falling edge.
  task automatic run_irq(input string tag,
                         input logic [31:0] sr, input logic [31:0] pc,
                         input logic [31:0] sp, input logic [31:0] vbr,
                         input logic [3:0] lvl, input logic [7:0] vec,
                         input logic [31:0] rd, input int busy_n, input int vw_n,
                         input int drop_at, input int ce_at, input int ce_n);
    logic [31:0] exp_sr, exp_sp, exp_ra, snap_a;
    int exp_lat, lat, acks;
    exp_sp  = sp - 32'd8;
    exp_ra  = vbr + 32'(vec) * 32'd4;
    exp_sr  = (sr & ~32'hF0) | (32'((vec == 8'd11) ? 4'hF : lvl) << 4);
    exp_lat = 7 + 3 * busy_n + ((vw_n > 1) ? vw_n - 1 : 0) + ce_n;

    ifc.sr_in_i = sr;  ifc.pc_in_i = pc;  ifc.sp_in_i = sp;  ifc.vbr_i = vbr;
    ifc.int_lvl_i = lvl;  ifc.int_vec_i = vec;
    ifc.int_req_i = 1'b1;  ifc.inst_bound_i = 1'b1;
    busy_cfg = busy_n;  vw_cfg = vw_n;  rd_cfg = rd;
    log_a.delete();  log_d.delete();  log_we.delete();
    snap_a = 32'h0;

    @(posedge clk);
    lat  = -1;
    acks = 0;
    for (int e = 1; e <= 300; e++) begin
      @(negedge clk);
      acks += int'(ifc.int_ack_o);
      if (e == 1) begin
        check({tag, "_ack_t1"}, 32'(ifc.int_ack_o), 32'd1);
        check({tag, "_acp_t1"}, 32'(ifc.int_acp_o), 32'd1);
        check({tag, "_mask_busy"}, 32'(ifc.int_mask_o), 32'hF);
      end
      if (e == drop_at) ifc.int_req_i = 1'b0;
      if (ce_n > 0 && e == ce_at) begin
        snap_a = ifc.bus_a_o;
        ce = 1'b0;
      end else if (ce_n > 0 && e == ce_at + ce_n) begin
        check({tag, "_ce_frozen_a"}, ifc.bus_a_o, snap_a);
        ce = 1'b1;
      end
      if (ifc.load_o) begin
        lat = e;
        break;
      end
    end
    check({tag, "_load_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_ack_pulses"}, 32'(acks), 32'd1);
    check({tag, "_new_pc"}, ifc.new_pc_o, rd);
    check({tag, "_new_sr"}, ifc.new_sr_o, exp_sr);
    check({tag, "_new_sp"}, ifc.new_sp_o, exp_sp);
    check({tag, "_nxfer"}, 32'(log_a.size()), 32'd3);
    if (log_a.size() >= 3) begin
      check({tag, "_sr_addr"}, log_a[0], sp - 32'd4);
      check({tag, "_sr_data"}, log_d[0], sr);
      check({tag, "_sr_we"}, 32'(log_we[0]), 32'd1);
      check({tag, "_pc_addr"}, log_a[1], exp_sp);
      check({tag, "_pc_data"}, log_d[1], pc);
      check({tag, "_pc_we"}, 32'(log_we[1]), 32'd1);
      check({tag, "_rd_addr"}, log_a[2], exp_ra);
      check({tag, "_rd_we"}, 32'(log_we[2]), 32'd0);
    end
    @(negedge clk);
    check({tag, "_load_one_cycle"}, 32'(ifc.load_o), 32'd0);
    check({tag, "_acp_idle"}, 32'(ifc.int_acp_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    int n;
    logic [31:0] r_sr;
    logic [3:0]  r_lvl;
    logic [7:0]  r_vec;

    ifc.int_req_i = 1'b0;  ifc.int_lvl_i = 4'h0;  ifc.int_vec_i = 8'h0;
    ifc.vect_wait_i = 1'b0;  ifc.inst_bound_i = 1'b0;
    ifc.sr_in_i = 32'h0000_00A0;  ifc.pc_in_i = 32'h0;
    ifc.sp_in_i = 32'h0;  ifc.vbr_i = 32'h0;
    ifc.bus_di_i = 32'h0;  ifc.bus_busy_i = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_mask", 32'(ifc.int_mask_o), 32'hA);
    check("rst_ack", 32'(ifc.int_ack_o), 32'd0);
    check("rst_acp", 32'(ifc.int_acp_o), 32'd0);
    check("rst_vect_req", 32'(ifc.vect_req_o), 32'd0);
    check("rst_bus_req", 32'(ifc.bus_req_o), 32'd0);
    check("rst_load", 32'(ifc.load_o), 32'd0);
    check("rst_new_pc", ifc.new_pc_o, 32'h0);
    rst = 1'b0;

    // Level equal to the mask is refused.
    ifc.sr_in_i = 32'h30;  ifc.int_lvl_i = 4'd3;  ifc.int_vec_i = 8'd64;
    ifc.int_req_i = 1'b1;  ifc.inst_bound_i = 1'b1;
    acks = 0;
    repeat (10) begin @(negedge clk); acks += int'(ifc.int_ack_o); end
    check("masked_eq_ack", 32'(acks), 32'd0);
    check("masked_eq_acp", 32'(ifc.int_acp_o), 32'd0);
    check("masked_eq_mask", 32'(ifc.int_mask_o), 32'h3);

    // Level 5 under SR mask F is refused, then accepted once SR drops to 0x30.
    ifc.sr_in_i = 32'hF0;  ifc.int_lvl_i = 4'd5;
    acks = 0;
    repeat (4) begin @(negedge clk); acks += int'(ifc.int_ack_o); end
    check("masked_f_ack", 32'(acks), 32'd0);
    run_irq("irq0", 32'h30, 32'h1000, 32'h0FFF_F000, 32'h0, 4'd5, 8'd64,
            32'h2000, 0, 0, 1, 0, 0);

    // NMI under full mask.
    run_irq("nmi", 32'h0000_00F3, 32'h2222, 32'h0000_8000, 32'h0, 4'd15, 8'd11,
            32'h3000, 0, 0, 1, 0, 0);

    // Wait states on every transfer and on the vector handshake.
    run_irq("wait", 32'h10, 32'h4000, 32'h0002_0000, 32'h100, 4'd7, 8'd80,
            32'h5000, 2, 3, 1, 0, 0);

    // INST_BOUND gating.
    ifc.sr_in_i = 32'h20;  ifc.int_lvl_i = 4'd6;  ifc.int_vec_i = 8'd70;
    ifc.int_req_i = 1'b1;  ifc.inst_bound_i = 1'b0;
    acks = 0;
    repeat (5) begin @(negedge clk); acks += int'(ifc.int_ack_o); end
    check("ibound_ack", 32'(acks), 32'd0);
    check("ibound_acp", 32'(ifc.int_acp_o), 32'd0);
    run_irq("ibound", 32'h20, 32'h6000, 32'h0003_0000, 32'h0, 4'd6, 8'd70,
            32'h7000, 0, 0, 1, 0, 0);

    // Request withdrawn at t3; sequence must still complete.
    run_irq("drop_t3", 32'h0, 32'h8000, 32'h0004_0000, 32'h0, 4'd2, 8'd90,
            32'h9000, 0, 0, 3, 0, 0);

    // Clock enable low for four cycles mid-sequence.
    run_irq("ce_gap", 32'h50, 32'hA000, 32'h0005_0000, 32'h200, 4'd9, 8'd100,
            32'hB000, 0, 0, 1, 3, 4);

    // Stack and vector address wrap.
    run_irq("wrap", 32'h0, 32'hC000, 32'h0000_0004, 32'hFFFF_FF00, 4'd1, 8'd72,
            32'hD000, 0, 0, 1, 0, 0);

    // Reset during VECT, then a fresh sequence with the request still held.
    ifc.sr_in_i = 32'h40;  ifc.pc_in_i = 32'h4444;  ifc.sp_in_i = 32'h8000;
    ifc.vbr_i = 32'h100;  ifc.int_lvl_i = 4'd9;  ifc.int_vec_i = 8'd80;
    ifc.int_req_i = 1'b1;  ifc.inst_bound_i = 1'b1;
    busy_cfg = 0;  vw_cfg = 0;
    @(posedge clk);
    repeat (4) @(negedge clk);
    check("pre_rst_vect_req", 32'(ifc.vect_req_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_bus_req", 32'(ifc.bus_req_o), 32'd0);
    check("mid_rst_vect_req", 32'(ifc.vect_req_o), 32'd0);
    check("mid_rst_acp", 32'(ifc.int_acp_o), 32'd0);
    check("mid_rst_load", 32'(ifc.load_o), 32'd0);
    check("mid_rst_mask", 32'(ifc.int_mask_o), 32'h4);
    @(negedge clk);
    check("mid_rst_held_load", 32'(ifc.load_o), 32'd0);
    rst = 1'b0;
    run_irq("after_rst", 32'h40, 32'h4444, 32'h8000, 32'h100, 4'd9, 8'd80,
            32'hE000, 0, 0, 1, 0, 0);

    // Back-to-back acceptance: LOAD pulses eight cycles apart.
    run_irq("b2b", 32'h0, 32'h1234, 32'h0006_0000, 32'h0, 4'd4, 8'd66,
            32'hF000, 0, 0, 0, 0, 0);
    n = 0;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      n++;
      if (ifc.load_o) break;
    end
    check("b2b_spacing", 32'(n + 1), 32'd8);
    ifc.int_req_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("b2b_idle", 32'(ifc.int_acp_o), 32'd0);

    // Randomized interrupts against the model.
    for (int k = 0; k < 8; k++) begin
      r_sr = $urandom;
      if (r_sr[7:4] == 4'hF) begin
        r_vec = 8'd11;
        r_lvl = 4'($urandom_range(15, 0));
      end else begin
        r_vec = 8'($urandom_range(255, 0));
        r_lvl = 4'($urandom_range(15, int'(r_sr[7:4]) + 1));
      end
      run_irq($sformatf("rnd%0d", k), r_sr, $urandom, $urandom, $urandom,
              r_lvl, r_vec, $urandom, int'($urandom_range(2, 0)),
              int'($urandom_range(3, 0)), 1, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
